// File: rtl/dmem_arbiter.sv
// Two-requester (core C, debug D) arbiter for a single-port data memory.
// IDLE grants one access combinationally; RESP returns the registered memory response.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [CNT_W-1:0]  conflicts
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;   // 0 = core, 1 = debug
  logic               last_q, last_d;     // most recent winner, same encoding
  logic               wr_q, wr_d;         // owner's access was a store
  logic [CNT_W-1:0]   conflicts_q, conflicts_d;
  logic               c_win, d_win;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      wr_q        <= 1'b0;
      conflicts_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wr_q        <= wr_d;
      conflicts_q <= conflicts_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wr_d        = wr_q;
    conflicts_d = conflicts_q;
    c_win       = 1'b0;
    d_win       = 1'b0;
    c_gnt       = 1'b0;
    d_gnt       = 1'b0;
    c_rvalid    = 1'b0;
    d_rvalid    = 1'b0;
    c_rdata     = '0;
    d_rdata     = '0;
    m_en        = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    // Outputs are forced quiet while reset is held, even if requests are high.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          c_win = c_req & (~d_req | last_q);
          d_win = d_req & ~c_win;
          if (c_req & d_req) conflicts_d = sat_inc(conflicts_q);
          if (c_win) begin
            c_gnt   = 1'b1;
            m_en    = 1'b1;
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
            owner_d = 1'b0;
            last_d  = 1'b0;
            wr_d    = c_we;
            state_d = RESP;
          end else if (d_win) begin
            d_gnt   = 1'b1;
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            owner_d = 1'b1;
            last_d  = 1'b1;
            wr_d    = d_we;
            state_d = RESP;
          end
        end
        RESP: begin
          if (owner_q) begin
            d_rvalid = 1'b1;
            d_rdata  = wr_q ? '0 : m_rdata;
          end else begin
            c_rvalid = 1'b1;
            c_rdata  = wr_q ? '0 : m_rdata;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign c_stall   = ~reset & c_req & ~c_rvalid;
  assign conflicts = conflicts_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: cycle table, directed sequences and
// randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  logic        clk, reset;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [15:0] conflicts;

  logic        c_gnt2, c_rvalid2, c_stall2, d_gnt2, d_rvalid2, m_en2, m_we2;
  logic [31:0] c_rdata2, d_rdata2, m_addr2, m_wdata2;
  logic [1:0]  conflicts2;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .conflicts(conflicts)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt2), .c_rvalid(c_rvalid2), .c_rdata(c_rdata2), .c_stall(c_stall2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
    .m_en(m_en2), .m_we(m_we2), .m_addr(m_addr2), .m_wdata(m_wdata2),
    .m_rdata(m_rdata), .conflicts(conflicts2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory array: 16 words, read data one cycle after the strobe.
  logic [31:0] mem [16];
  logic        mem_clr;
  initial m_rdata = '0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (m_en) begin
      if (m_we) mem[m_addr[5:2]] <= m_wdata;
      else      m_rdata <= mem[m_addr[5:2]];
    end
  end

  int n_chk, n_fail;

  // Reference model: pending-response flag, owner, last winner, shadow memory.
  bit          busy, own, lst, pwr;
  logic [31:0] prd;
  int          cnt;
  logic [31:0] sh [16];

  logic        s_cg, s_dg, s_crv, s_drv, s_men, s_mwe, s_cst;
  logic [31:0] s_crd, s_drd;
  logic [15:0] s_conf;
  logic [1:0]  s_conf2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 0; own = 0; lst = 1; pwr = 0; prd = '0; cnt = 0;
    for (int i = 0; i < 16; i++) sh[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_clr = 1'b1;
    c_req = 1'b1; d_req = 1'b1; c_we = 0; d_we = 0;
    c_addr = '0; d_addr = '0; c_wdata = '0; d_wdata = '0;
    #1;
    chk("rst_ctl", {c_gnt, d_gnt, c_rvalid, d_rvalid, m_en, m_we, c_stall}, 7'd0);
    @(posedge clk); #1;
    chk("rst_conf", conflicts, 16'd0);
    c_req = 0; d_req = 0; mem_clr = 1'b0; reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, compare, advance model.
  task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bit          w_c, w_d, e_crv, e_drv;
    logic [31:0] e_ma, e_mwd;
    logic        e_mwe;
    int          e_c2;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #4;
    w_c   = !busy && cr && (!dr || lst);
    w_d   = !busy && dr && !w_c;
    e_crv = busy && !own;
    e_drv = busy && own;
    e_mwe = w_c ? cw : (w_d ? dw : 1'b0);
    e_ma  = w_c ? ca : (w_d ? da : 32'd0);
    e_mwd = w_c ? cd : (w_d ? dd : 32'd0);
    e_c2  = (cnt > 3) ? 3 : cnt;
    s_cg = c_gnt; s_dg = d_gnt; s_crv = c_rvalid; s_drv = d_rvalid;
    s_men = m_en; s_mwe = m_we; s_cst = c_stall; s_crd = c_rdata; s_drd = d_rdata;
    s_conf = conflicts; s_conf2 = conflicts2;
    chk("ctl", {s_cg, s_dg, s_crv, s_drv, s_men, s_mwe, s_cst},
        {w_c, w_d, e_crv, e_drv, (w_c | w_d), e_mwe, (cr && !e_crv)});
    chk("m_addr", m_addr, e_ma);
    chk("m_wdata", m_wdata, e_mwd);
    chk("c_rdata", s_crd, (e_crv && !pwr) ? prd : 32'd0);
    chk("d_rdata", s_drd, (e_drv && !pwr) ? prd : 32'd0);
    chk("conflicts", s_conf, cnt);
    chk("conflicts_w2", s_conf2, e_c2);
    if (busy) begin
      busy = 0;
    end else begin
      if (cr && dr && cnt < 65535) cnt++;
      if (w_c || w_d) begin
        busy = 1; own = w_d; lst = w_d; pwr = e_mwe;
        if (e_mwe) sh[e_ma[5:2]] = e_mwd;
        else       prd = sh[e_ma[5:2]];
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic cr, dr;
    logic cg, dg, crv, drv, men, cst;
    int   conf;
  } vec_t;
  vec_t tbl [12];

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; mem_clr = 1'b1;
    c_req = 0; d_req = 0; c_we = 0; d_we = 0;
    c_addr = '0; d_addr = '0; c_wdata = '0; d_wdata = '0;

    // cr dr | cg dg crv drv men cst | conflicts
    tbl[0]  = '{1,1, 1,0,0,0,1,1, 0};
    tbl[1]  = '{1,1, 0,0,1,0,0,0, 1};
    tbl[2]  = '{1,1, 0,1,0,0,1,1, 1};
    tbl[3]  = '{1,1, 0,0,0,1,0,1, 2};
    tbl[4]  = '{1,1, 1,0,0,0,1,1, 2};
    tbl[5]  = '{1,1, 0,0,1,0,0,0, 3};
    tbl[6]  = '{0,1, 0,1,0,0,1,0, 3};
    tbl[7]  = '{0,1, 0,0,0,1,0,0, 3};
    tbl[8]  = '{0,1, 0,1,0,0,1,0, 3};
    tbl[9]  = '{0,1, 0,0,0,1,0,0, 3};
    tbl[10] = '{0,1, 0,1,0,0,1,0, 3};
    tbl[11] = '{0,1, 0,0,0,1,0,0, 3};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].cr, 0, 32'h0, 32'h0, tbl[i].dr, 0, 32'h4, 32'h0);
      chk($sformatf("tbl%0d_ctl", i), {s_cg, s_dg, s_crv, s_drv, s_men, s_cst},
          {tbl[i].cg, tbl[i].dg, tbl[i].crv, tbl[i].drv, tbl[i].men, tbl[i].cst});
      chk($sformatf("tbl%0d_conf", i), s_conf, tbl[i].conf);
    end

    // Core load of 0xDEADBEEF from 0x10, then store/load round trip at 0x20.
    do_reset();
    step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
    chk("ld_gnt_stall", {s_cg, s_cst}, 2'b11);
    step(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
    chk("ld_data", s_crd, 32'hDEADBEEF);
    chk("ld_rv_stall", {s_crv, s_cst}, 2'b10);
    step(1, 1, 32'h20, 32'h5, 0, 0, 0, 0);
    chk("st_mwe", {s_men, s_mwe}, 2'b11);
    step(1, 1, 32'h20, 32'h5, 0, 0, 0, 0);
    chk("st_ack", {s_crv, s_crd}, {1'b1, 32'h0});
    step(1, 0, 32'h20, 32'h0, 0, 0, 0, 0);
    step(1, 0, 32'h20, 32'h0, 0, 0, 0, 0);
    chk("st_ld_data", s_crd, 32'h5);

    // Contention for 5 IDLE cycles saturates the narrow counter.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_w16", s_conf, 16'd5);
    chk("sat_w2", s_conf2, 2'd3);

    // Reset asserted during the response cycle of a core load.
    do_reset();
    step(1, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0);
    c_req = 1; d_req = 0;
    #1;
    chk("mid_rv_before", c_rvalid, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rv_after", {c_rvalid, d_rvalid, c_stall}, 3'b000);
    chk("mid_conf", conflicts, 16'd0);
    c_req = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) sh[i] = mem[i];
    #1;
    chk("no_replay", {c_rvalid, d_rvalid}, 2'b00);
    step(1, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("post_rst_gnt", s_cg, 1'b1);
    step(1, 0, 32'h0, 32'h0, 0, 0, 0, 0);

    // Randomized traffic; requests may drop or change at any time.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
           $urandom_range(0, 1), $urandom_range(0, 1), {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
